sht40_responder: RTL

SHT40_RESPONDER -- requirements
Module: sht40_responder

---
 rtl/sht40_pkg.sv | 35 +++
 rtl/sht40_crc8_serial.sv | 63 ++++++
 rtl/sht40_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sht40_pkg.sv
// -----------------------------------------------------------------------------
// sht40_pkg
//   Shared definitions for the SHT40 sensor responder:
//     - state_t            : responder FSM states
//     - CRC_POLY / CRC_INIT: Sensirion CRC-8 parameters (0x31, init 0xFF)
//     - DEF_CMD_*          : default command opcodes
//     - FRAME_LEN          : bytes in one measurement frame (T, T, CRC, RH, RH, CRC)
//     - CRC_CYCLES         : clk cycles spent in CRC_CALC (4 bytes x 8 bits)
//     - crc8_bit_step()    : one MSB-first shift of the CRC register
// -----------------------------------------------------------------------------
package sht40_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        CRC_CALC = 2'd2,
        READY    = 2'd3
    } state_t;

    localparam logic [7:0] CRC_POLY           = 8'h31;
    localparam logic [7:0] CRC_INIT           = 8'hFF;

    localparam logic [7:0] DEF_CMD_MEASURE    = 8'hFD;
    localparam logic [7:0] DEF_CMD_SOFT_RESET = 8'h94;

    localparam int         FRAME_LEN          = 6;
    localparam int         CRC_CYCLES         = 32;

    // One bit of the CRC: shift left, fold the polynomial in when the
    // outgoing MSB was set.
    function automatic logic [7:0] crc8_bit_step(input logic [7:0] c);
        return c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/sht40_crc8_serial.sv
// -----------------------------------------------------------------------------
// sht40_crc8_serial
//   Bit-serial CRC-8 (poly 0x31, init 0xFF, MSB first, no reflection, no
//   final XOR). One bit is processed per shift cycle; the byte on data_byte is
//   XORed into the register in the first shift cycle of each byte, which is
//   tracked by an internal 3-bit bit counter.
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset, clears register and counter
//     load      in   reinitialise to CRC_INIT; combined with shift, the shift
//                    starts from CRC_INIT so a new message costs no extra cycle
//     shift     in   process one bit
//     data_byte in   byte currently being folded in (must be stable for the
//                    8 shift cycles of that byte)
//     crc       out  current CRC register value
// -----------------------------------------------------------------------------
module sht40_crc8_serial
    import sht40_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] data_byte,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [2:0] bit_cnt_q;

    logic [7:0] crc_base;
    logic [2:0] cnt_base;
    logic [7:0] crc_mixed;
    logic [7:0] crc_next;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here unconditionally); a path that leaves one unassigned infers a latch.
    always_comb begin
        crc_base  = load ? CRC_INIT : crc_q;
        cnt_base  = load ? 3'd0 : bit_cnt_q;
        crc_mixed = (cnt_base == 3'd0) ? (crc_base ^ data_byte) : crc_base;
        crc_next  = crc8_bit_step(crc_mixed);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q     <= 8'h00;
            bit_cnt_q <= 3'd0;
        end else if (shift) begin
            crc_q     <= crc_next;
            bit_cnt_q <= cnt_base + 3'd1;
        end else if (load) begin
            crc_q     <= CRC_INIT;
            bit_cnt_q <= 3'd0;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sht40_responder.sv
// -----------------------------------------------------------------------------
// sht40_responder
//   Emulates the command/response behaviour of an SHT40 humidity/temperature
//   sensor behind an I2C target PHY. A measure command starts a timed
//   measurement, the raw values are latched, both CRC-8 checksums are computed
//   bit-serially, and the 6-byte frame is then served one byte per rd_req.
//
//   Optional feature: define SHT40_RESP_CRC_INJ_EN to add input crc_corrupt,
//   which flips bit 0 of a CRC byte (byte 2 or 5) when high at its read.
//
//   Parameters
//     MEAS_CYCLES     clk cycles the emulated measurement takes
//     CMD_MEASURE     measurement command opcode
//     CMD_SOFT_RESET  soft-reset command opcode
//
//   Ports
//     clk         in   clock, rising edge
//     rst_n       in   synchronous active-low reset
//     cmd_valid   in   one-cycle pulse, command byte written by the controller
//     cmd_data    in   command byte
//     rd_req      in   one-cycle pulse, PHY wants the next read byte
//     temp_in     in   raw temperature to report
//     rh_in       in   raw humidity to report
//     crc_corrupt in   (SHT40_RESP_CRC_INJ_EN only) corrupt served CRC byte
//     rd_data     out  byte supplied to the PHY, held while rd_valid is low
//     rd_valid    out  one-cycle pulse qualifying rd_data
//     rd_nack     out  one-cycle pulse, no data available, PHY must NACK
//     busy        out  high in MEASURE or CRC_CALC
//     data_ready  out  high in READY
//     byte_idx    out  index 0..5 of the next byte to be served
// -----------------------------------------------------------------------------
module sht40_responder
    import sht40_pkg::*;
#(
    parameter int         MEAS_CYCLES    = 1000,
    parameter logic [7:0] CMD_MEASURE    = DEF_CMD_MEASURE,
    parameter logic [7:0] CMD_SOFT_RESET = DEF_CMD_SOFT_RESET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    input  logic        rd_req,
    input  logic [15:0] temp_in,
    input  logic [15:0] rh_in,
`ifdef SHT40_RESP_CRC_INJ_EN
    input  logic        crc_corrupt,
`endif
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_nack,
    output logic        busy,
    output logic        data_ready,
    output logic [2:0]  byte_idx
);

    localparam int                CNT_W     = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  MEAS_LAST = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(FRAME_LEN - 1);
    localparam logic [4:0]        CRC_LAST  = 5'(CRC_CYCLES - 1);

    // ---------------------------------------------------------------- state
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic [4:0]       crc_cnt_q,  crc_cnt_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_nack_q,  rd_nack_d;
    logic [15:0]      temp_q;
    logic [15:0]      rh_q;
    logic [7:0]       t_crc_q;

    logic             latch_en;
    logic             t_crc_cap;
    logic             crc_load;
    logic             crc_shift;
    logic [7:0]       crc_byte;
    logic [7:0]       crc_value;
    logic [7:0]       crc_flip;
    logic [7:0]       frame_byte;
    logic             is_measure;
    logic             is_soft_reset;

    assign is_measure    = cmd_valid && (cmd_data == CMD_MEASURE);
    assign is_soft_reset = cmd_valid && (cmd_data == CMD_SOFT_RESET);

`ifdef SHT40_RESP_CRC_INJ_EN
    assign crc_flip = {7'd0, crc_corrupt};
`else
    assign crc_flip = 8'h00;
`endif

    // ------------------------------------------------------------ CRC engine
    // crc_cnt[4:3] selects the byte (T msb, T lsb, RH msb, RH lsb); the engine
    // is reloaded at the start of each 16-bit word.
    always_comb begin
        unique case (crc_cnt_q[4:3])
            2'd0:    crc_byte = temp_q[15:8];
            2'd1:    crc_byte = temp_q[7:0];
            2'd2:    crc_byte = rh_q[15:8];
            default: crc_byte = rh_q[7:0];
        endcase
    end

    sht40_crc8_serial u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (crc_load),
        .shift     (crc_shift),
        .data_byte (crc_byte),
        .crc       (crc_value)
    );

    // -------------------------------------------------------- frame select
    // The humidity CRC is taken straight from the engine: it only shifts in
    // CRC_CALC, so its register is stable for the whole READY phase.
    always_comb begin
        unique case (byte_idx_q)
            3'd0:    frame_byte = temp_q[15:8];
            3'd1:    frame_byte = temp_q[7:0];
            3'd2:    frame_byte = t_crc_q ^ crc_flip;
            3'd3:    frame_byte = rh_q[15:8];
            3'd4:    frame_byte = rh_q[7:0];
            3'd5:    frame_byte = crc_value ^ crc_flip;
            default: frame_byte = 8'h00;
        endcase
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d    = state_q;
        meas_cnt_d = meas_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        byte_idx_d = byte_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_nack_d  = 1'b0;
        latch_en   = 1'b0;
        t_crc_cap  = 1'b0;
        crc_load   = 1'b0;
        crc_shift  = 1'b0;

        if (cmd_valid) begin
            // A command always wins over a simultaneous read request.
            rd_nack_d = rd_req;
            if (is_measure) begin
                state_d    = MEASURE;
                meas_cnt_d = '0;
                byte_idx_d = 3'd0;
            end else if (is_soft_reset) begin
                state_d    = IDLE;
                byte_idx_d = 3'd0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    rd_nack_d = rd_req;
                end

                MEASURE: begin
                    rd_nack_d = rd_req;
                    if (meas_cnt_q == MEAS_LAST) begin
                        latch_en  = 1'b1;
                        crc_cnt_d = 5'd0;
                        state_d   = CRC_CALC;
                    end else begin
                        meas_cnt_d = meas_cnt_q + CNT_W'(1);
                    end
                end

                CRC_CALC: begin
                    rd_nack_d = rd_req;
                    crc_shift = 1'b1;
                    crc_load  = (crc_cnt_q[3:0] == 4'd0);
                    // Temperature CRC is complete when the humidity word starts.
                    t_crc_cap = (crc_cnt_q == 5'd16);
                    if (crc_cnt_q == CRC_LAST) begin
                        state_d = READY;
                    end else begin
                        crc_cnt_d = crc_cnt_q + 5'd1;
                    end
                end

                READY: begin
                    if (rd_req) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = frame_byte;
                        if (byte_idx_q == LAST_BYTE) begin
                            byte_idx_d = 3'd0;
                            state_d    = IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            meas_cnt_q <= '0;
            crc_cnt_q  <= 5'd0;
            byte_idx_q <= 3'd0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_nack_q  <= 1'b0;
            temp_q     <= 16'h0000;
            rh_q       <= 16'h0000;
            t_crc_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            meas_cnt_q <= meas_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            byte_idx_q <= byte_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_nack_q  <= rd_nack_d;
            if (latch_en) begin
                temp_q <= temp_in;
                rh_q   <= rh_in;
            end
            if (t_crc_cap) begin
                t_crc_q <= crc_value;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_nack    = rd_nack_q;
    assign byte_idx   = byte_idx_q;
    assign busy       = (state_q == MEASURE) || (state_q == CRC_CALC);
    assign data_ready = (state_q == READY);

endmodule
